// File: rtl/kernel_streamer.sv
// rtl/kernel_streamer.sv - serializes a flat kernel word into kernel_mem; optional readback check under KERNEL_STREAM_VERIFY_EN
module kernel_streamer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_vec,
  input  logic                                    stall,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic                                    kmem_clear,
  output logic                                    kmem_write_en,
  output logic [BITS-1:0]                         kmem_kernel_in,
  input  logic                                    kmem_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kmem_out
);

  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    WAIT_RDY,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [1:0]          wcnt, wcnt_n;
  logic [N*BITS-1:0]   cap, cap_n;
  logic                busy_n, done_n, err_n, clear_n, we_n;
  logic [BITS-1:0]     kin_n;
  logic [BITS-1:0]     cap_elem [N];

`ifndef KERNEL_STREAM_VERIFY_EN
  // kmem_out only matters for the readback check; fold it so it is not left dangling
  logic unused_kmem_out;
  assign unused_kmem_out = ^kmem_out;
`endif

  // Element view of the captured kernel for indexed selection
  always_comb begin
    for (int e = 0; e < N; e++) begin
      cap_elem[e] = cap[e*BITS +: BITS];
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    cap_n   = cap;
    err_n   = err;
    done_n  = 1'b0;
    clear_n = 1'b0;
    we_n    = 1'b0;
    kin_n   = kmem_kernel_in;
    case (state)
      IDLE: begin
        if (start) begin
          cap_n   = kernel_vec;
          err_n   = 1'b0;
          clear_n = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        // kernel_mem shifts, so the highest element goes in first
        cnt_n   = '0;
        we_n    = 1'b1;
        kin_n   = cap_elem[LAST];
        state_n = STREAM;
      end
      STREAM: begin
        if (kmem_write_en && cnt == LAST) begin
          wcnt_n  = '0;
          state_n = WAIT_RDY;
        end else begin
          // cnt tracks the element currently offered; it advances only when a write lands
          cnt_n = kmem_write_en ? cnt + CW'(1) : cnt;
          if (!stall) begin
            we_n  = 1'b1;
            kin_n = cap_elem[LAST - cnt_n];
          end
        end
      end
      WAIT_RDY: begin
        if (kmem_ready) begin
`ifdef KERNEL_STREAM_VERIFY_EN
          if (kmem_out == cap) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
`else
          done_n  = 1'b1;
          state_n = DONE;
`endif
        end else if (wcnt == 2'd3) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 2'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, counters, captured kernel and all outputs registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      wcnt           <= '0;
      cap            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      kmem_clear     <= 1'b0;
      kmem_write_en  <= 1'b0;
      kmem_kernel_in <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      wcnt           <= wcnt_n;
      cap            <= cap_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
      kmem_clear     <= clear_n;
      kmem_write_en  <= we_n;
      kmem_kernel_in <= kin_n;
    end
  end

endmodule

// File: tb/tb_kernel_streamer.sv
// tb/tb_kernel_streamer.sv - directed bench for kernel_streamer with a shifting kernel_mem model
module tb_kernel_streamer;

  localparam int N = 9;
  localparam int B = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           stall;
  logic [N*B-1:0] kernel_vec;
  logic           busy, done, err, kmem_clear, kmem_write_en;
  logic [B-1:0]   kmem_kernel_in;
  logic           kmem_ready;
  logic [N*B-1:0] kmem_out;

  kernel_streamer #(.BITS(B), .KERNEL_SIZE(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .kernel_vec     (kernel_vec),
    .stall          (stall),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .kmem_clear     (kmem_clear),
    .kmem_write_en  (kmem_write_en),
    .kmem_kernel_in (kmem_kernel_in),
    .kmem_ready     (kmem_ready),
    .kmem_out       (kmem_out)
  );

  always #5 clk = ~clk;

  // kernel_mem model: shift in at index 0, ready after N writes since the last clear
  logic [B-1:0] mem [N];
  int           wrn;
  logic         mrdy;
  bit           tie0 = 1'b0;
  bit           bad0 = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset || kmem_clear) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wrn  <= 0;
      mrdy <= 1'b0;
    end else if (kmem_write_en) begin
      mem[0] <= kmem_kernel_in;
      for (int i = 1; i < N; i++) mem[i] <= mem[i-1];
      wrn  <= wrn + 1;
      mrdy <= (wrn + 1 >= N);
    end
  end

  always_comb begin
    kmem_out = '0;
    for (int e = 0; e < N; e++) kmem_out[e*B +: B] = mem[e];
    if (bad0) kmem_out[B-1:0] = 9'h1FF;
  end

  assign kmem_ready = mrdy & ~tie0;

  // Cycle bookkeeping relative to the start-sampling edge T0
  int           cyc = 0;
  int           t0 = 0;
  logic [B-1:0] wq [$];
  int           done_cnt, done_rel, clear_cnt, err_rel;
  logic         busy1, clear1, err1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int rel;
    rel = cyc + 1 - t0;
    if (reset) begin
      if (kmem_write_en) wq.push_back(kmem_kernel_in);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_rel = rel;
      end
      if (kmem_clear) clear_cnt = clear_cnt + 1;
      if (err && err_rel < 0) err_rel = rel;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic reset_mon();
    wq.delete();
    done_cnt  = 0;
    done_rel  = -1;
    clear_cnt = 0;
    err_rel   = -1;
  endtask

  // One load: start high for hold_len cycles, stall high for cycles stall_at..stall_at+stall_n-1
  task automatic run_load(input int stall_at, input int stall_n, input int hold_len, input int ncyc);
    @(negedge clk);
    reset_mon();
    start = 1'b1;
    t0    = cyc + 1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1  = busy;
        clear1 = kmem_clear;
        err1   = err;
      end
      start = (k < hold_len);
      stall = (k >= stall_at) && (k < stall_at + stall_n);
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wq.size(), N);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_wr%0d", tag, i), (i < wq.size()) ? 32'(wq[i]) : 32'hFFF, N - i);
  endtask

  logic [N*B-1:0] vec_a, vec_b;

  initial begin
    for (int e = 0; e < N; e++) begin
      vec_a[e*B +: B] = B'(e + 1);
      vec_b[e*B +: B] = B'(e * 37 + 5);
    end
    reset      = 1'b1;
    start      = 1'b0;
    stall      = 1'b0;
    kernel_vec = vec_a;
    reset_mon();

    // Reset state, observed before any clock edge
    #2 reset = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_clear", kmem_clear, 0);
    check("rst_we", kmem_write_en, 0);
    check("rst_kin", kmem_kernel_in, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Plain load: writes 9..1, done at T0+12, mem element e = e+1
    run_load(0, 0, 1, 20);
    check("a_busy1", busy1, 1);
    check("a_clear1", clear1, 1);
    check("a_nclear", clear_cnt, 1);
    check_writes("a");
    check("a_ndone", done_cnt, 1);
    check("a_done_at", done_rel, 12);
    check("a_err", err, 0);
    check("a_busy_end", busy, 0);
    for (int e = 0; e < N; e++) check($sformatf("a_mem%0d", e), mem[e], e + 1);

    // kernel_vec change after capture must not matter; stall 3 cycles at c=4
    fork
      run_load(6, 3, 1, 24);
      begin
        repeat (3) @(negedge clk);
        kernel_vec = vec_b;
      end
    join
    kernel_vec = vec_a;
    check_writes("s");
    check("s_ndone", done_cnt, 1);
    check("s_done_at", done_rel, 15);

    // ready never rises: timeout after 4 WAIT_RDY cycles, no done
    tie0 = 1'b1;
    run_load(0, 0, 1, 20);
    tie0 = 1'b0;
    check("t_ndone", done_cnt, 0);
    check("t_err_at", err_rel, 15);
    check("t_err", err, 1);
    check("t_busy", busy, 0);

    // Next accepted start clears err
    kernel_vec = vec_b;
    run_load(0, 0, 1, 20);
    check("c_err1", err1, 0);
    check("c_ndone", done_cnt, 1);
    check("c_mem0", mem[0], 5);
    check("c_mem8", mem[8], 8 * 37 + 5);
    kernel_vec = vec_a;

    // start held high: one load per IDLE visit, start ignored while busy
    run_load(0, 0, 26, 46);
    check("h_nclear", clear_cnt, 2);
    check("h_ndone", done_cnt, 2);
    check("h_done_at", done_rel, 25);
    check("h_nwr", wq.size(), 2 * N);

    // Corrupted readback element 0
    bad0 = 1'b1;
    run_load(0, 0, 1, 20);
    bad0 = 1'b0;
`ifdef KERNEL_STREAM_VERIFY_EN
    check("v_ndone", done_cnt, 0);
    check("v_err", err, 1);
    check("v_err_at", err_rel, 12);
`else
    check("v_ndone", done_cnt, 1);
    check("v_err", err, 0);
    check("v_done_at", done_rel, 12);
`endif

    // Asynchronous reset in the middle of STREAM
    @(negedge clk);
    reset_mon();
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("m_busy_pre", busy, 1);
    check("m_we_pre", kmem_write_en, 1);
    reset = 1'b0;
    #1;
    check("m_busy", busy, 0);
    check("m_done", done, 0);
    check("m_err", err, 0);
    check("m_clear", kmem_clear, 0);
    check("m_we", kmem_write_en, 0);
    check("m_kin", kmem_kernel_in, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("m_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
